ysyx_24090018_ifu: RTL and testbench

Instruction fetch unit for the NPC core. Holds the architectural PC, fetches one 32-bit instruction per architectural step over a valid/ready request/response memory port, and presents `{pc, inst}` to the decode stage, whose key-lookup decoders select on `inst` fields. The core is non-pipelined: after decode accepts an instruction, the IFU stalls until the commit stage returns the next PC.

---
 rtl/ysyx_24090018_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_24090018_ifu.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090018_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per architectural step
// over a valid/ready memory port and presents {pc, inst} to decode.
module ysyx_24090018_ifu #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [31:0]       resp_data,
    input  logic              resp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_err,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT_NPC  = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              err_q, err_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;

    // Next-state and datapath update for the fetch sequence.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        err_d       = err_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = ST_WAIT_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_valid) begin
                    // A faulting fetch never exposes the bus data to decode.
                    inst_d  = resp_err ? 32'h0000_0000 : resp_data;
                    err_d   = resp_err;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = ST_WAIT_NPC;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT_NPC: begin
                if (npc_valid) begin
                    // Misalignment is reported by commit; here it is only masked.
                    pc_d    = npc & WORD_MASK;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT_NPC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC, fetched word and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'h0000_0000;
            err_q       <= 1'b0;
            fetch_cnt_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            err_q       <= err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign req_valid  = (state_q == ST_REQ);
    assign resp_ready = (state_q == ST_WAIT_RESP);
    assign out_valid  = (state_q == ST_HOLD);
    assign req_addr   = pc_q;
    assign out_pc     = pc_q;
    assign out_inst   = inst_q;
    assign out_err    = err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_24090018_ifu.sv
// Randomized scoreboard bench for ysyx_24090018_ifu: memory and commit models
// push expected fetches, a monitor pops them at each decode handshake.
module tb_ysyx_24090018_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic        out_err;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] fetch_cnt;

    ysyx_24090018_ifu #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_err(out_err),
        .npc_valid(npc_valid), .npc(npc), .fetch_cnt(fetch_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -10;
    int rel_cyc = 0;

    // knobs
    int req_pct = 100, out_pct = 100, npc_pct = 100, err_pct = 0, resp_max = 0;
    bit seq_mode = 1'b1, garbage = 1'b0, fixed_first = 1'b0;

    logic [31:0] exp_addr_q[$];
    exp_t        exp_out_q[$];
    logic [31:0] model_cnt = 32'h0;
    logic [31:0] last_pc = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: accepts requests, returns random words after a random delay.
    initial begin
        bit          pending = 1'b0;
        bit          wait_prev = 1'b0;
        int          delay = 0;
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] cur_pc = 32'h0;
        logic [31:0] data;
        logic        err;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; resp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0; wait_prev = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
                continue;
            end
            check("resp_ready", 32'(resp_ready), 32'(pending));
            if (wait_prev && req_valid) check("req_addr_stable", req_addr, prev_addr);
            resp_valid = 1'b0;
            resp_data  = $urandom;
            resp_err   = 1'($urandom_range(1));
            if (pending) begin
                if (delay == 0) begin
                    data = $urandom;
                    err  = ($urandom_range(99) < err_pct);
                    if (fixed_first) begin
                        data = 32'h0000_0413; err = 1'b0; fixed_first = 1'b0;
                    end
                    resp_valid = 1'b1; resp_data = data; resp_err = err;
                    exp_out_q.push_back({cur_pc, (err ? 32'h0 : data), err});
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end else if (garbage && $urandom_range(99) < 30) begin
                resp_valid = 1'b1;
            end
            req_ready = ($urandom_range(99) < req_pct);
            wait_prev = req_valid && !req_ready;
            prev_addr = req_addr;
            if (req_valid && req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got %h expected no request", req_addr);
                end else begin
                    check("req_addr", req_addr, exp_addr_q.pop_front());
                end
                cur_pc  = req_addr;
                pending = 1'b1;
                delay   = $urandom_range(resp_max);
            end
        end
    end

    // Commit model: delivers the next PC once decode has taken an instruction.
    initial begin
        bit waiting = 1'b0;
        npc_valid = 1'b0; npc = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                waiting = 1'b0; npc_valid = 1'b0;
                continue;
            end
            if (cyc == hs_cyc + 1) waiting = 1'b1;
            npc_valid = 1'b0;
            npc = $urandom;
            if (waiting) begin
                if ($urandom_range(99) < npc_pct) begin
                    npc = seq_mode ? last_pc + 32'd4 : {2'b10, 30'($urandom)};
                    npc_valid = 1'b1;
                    exp_addr_q.push_back({npc[31:2], 2'b00});
                    waiting = 1'b0;
                end
            end else if (garbage && $urandom_range(99) < 30) begin
                npc_valid = 1'b1;
            end
        end
    end

    // Monitor: decode side, pops the scoreboard at each accepted instruction.
    initial begin
        bit          hold_prev = 1'b0;
        exp_t        prev_o;
        exp_t        e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0; out_ready = 1'b0;
                continue;
            end
            check("fetch_cnt", fetch_cnt, model_cnt);
            if (hold_prev) begin
                check("out_valid_held", 32'(out_valid), 32'd1);
                check("out_pc_stable", out_pc, prev_o.pc);
                check("out_inst_stable", out_inst, prev_o.inst);
                check("out_err_stable", 32'(out_err), 32'(prev_o.err));
            end
            out_ready = ($urandom_range(99) < out_pct);
            hold_prev = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
                    end else begin
                        e = exp_out_q.pop_front();
                        check("out_pc", out_pc, e.pc);
                        check("out_inst", out_inst, e.inst);
                        check("out_err", 32'(out_err), 32'(e.err));
                    end
                    model_cnt = model_cnt + 32'd1;
                    last_pc   = out_pc;
                    hs_cyc    = cyc;
                end else begin
                    hold_prev = 1'b1;
                    prev_o    = {out_pc, out_inst, out_err};
                end
            end
        end
    end

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_resp_ready", 32'(resp_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, RST_PC);
        check("rst_fetch_cnt", fetch_cnt, 32'h0);
        exp_addr_q.delete();
        exp_out_q.delete();
        model_cnt = 32'h0;
        hs_cyc = -10;
        exp_addr_q.push_back(RST_PC);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        #1;
        check("idle_req_valid", 32'(req_valid), 32'd0);
        @(negedge clk);
        check("first_req_valid", 32'(req_valid), 32'd1);
        check("first_req_addr", req_addr, RST_PC);
    endtask

    task automatic wait_cnt(input logic [31:0] target, input int budget);
        int n = 0;
        while (model_cnt != target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (model_cnt != target) begin
            checks++; errors++;
            $display("FAIL timeout_count: got %0d expected %0d", model_cnt, target);
        end
    endtask

    task automatic set_ideal();
        req_pct = 100; out_pct = 100; npc_pct = 100; err_pct = 0;
        resp_max = 0; seq_mode = 1'b1; garbage = 1'b0;
    endtask

    task automatic set_random();
        req_pct = 40; out_pct = 40; npc_pct = 50; err_pct = 30;
        resp_max = 5; seq_mode = 1'b0; garbage = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #2;
        set_ideal();
        fixed_first = 1'b1;
        assert_reset();
        repeat (2) @(negedge clk);
        release_reset();
        wait_cnt(32'd1, 50);
        @(negedge clk);
        check("first_fetch_cnt", fetch_cnt, 32'd1);

        set_random();
        wait_cnt(model_cnt + 32'd40, 4000);

        // reset while waiting for the memory response
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_ready && n < 200);
        check("reached_wait_resp", 32'(resp_ready), 32'd1);
        #2;
        assert_reset();
        release_reset();
        wait_cnt(32'd10, 1500);

        // reset while presenting to decode
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 200);
        check("reached_hold", 32'(out_valid), 32'd1);
        #2;
        assert_reset();
        release_reset();
        wait_cnt(32'd10, 1500);

        // back-to-back throughput
        set_ideal();
        #2;
        assert_reset();
        release_reset();
        wait_cnt(32'd100, 1000);
        @(negedge clk);
        check("b2b_fetch_cnt", fetch_cnt, 32'd100);
        check("b2b_cycles", 32'(cyc - rel_cyc), 32'd400);

        // counter wrap
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 50);
        check("wrap_in_hold", 32'(out_valid), 32'd1);
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        @(negedge clk);
        @(negedge clk);
        check("wrap_fetch_cnt", fetch_cnt, 32'h0);
        wait_cnt(32'd3, 100);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
